// File: rtl/damage_arbiter.sv
// Owns player and boss HP, serialising damage requests one per clock through a
// round-robin arbiter, with invulnerability and hit-flash frame timers.
//
// state | meaning
// IDLE  | menu; requests ignored, timers clear
// RUN   | fight in progress; one damage event granted per clock
// OVER  | a health register reached zero; requests ignored
module damage_arbiter #(
    parameter int NREQ         = 4,
    parameter int DMG_W        = 4,
    parameter int BOSS_HP_MAX  = 100,
    parameter int INVUL_FRAMES = 30,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic                  game_start,
    input  logic                  back_to_menu,
    input  logic [3:0]            char_hp_max,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_target,
    input  logic [NREQ*DMG_W-1:0] req_dmg,
    output logic [NREQ-1:0]       ack,
    output logic                  applied,
    output logic [3:0]            current_health,
    output logic [6:0]            boss_hp,
    output logic                  char_invul,
    output logic [1:0]            hit_flash
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int INV_W = $clog2(INVUL_FRAMES + 1);
    localparam int FL_W  = $clog2(FLASH_FRAMES + 1);
    localparam int SAT_W = (DMG_W > 7) ? DMG_W : 7;

    localparam logic [6:0]       BOSS_LOAD = 7'(BOSS_HP_MAX);
    localparam logic [INV_W-1:0] INV_LOAD  = INV_W'(INVUL_FRAMES);
    localparam logic [FL_W-1:0]  FL_LOAD   = FL_W'(FLASH_FRAMES);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic               pend_vld, pend_vld_nxt;
    logic [PTR_W-1:0]   pend_idx, pend_idx_nxt;
    logic               pend_tgt, pend_tgt_nxt;
    logic [DMG_W-1:0]   pend_dmg, pend_dmg_nxt;
    logic [NREQ-1:0]    ack_nxt;
    logic               applied_nxt;
    logic [3:0]         hp_nxt;
    logic [6:0]         boss_nxt;
    logic [INV_W-1:0]   inv_cnt, inv_nxt;
    logic [FL_W-1:0]    cf_cnt, cf_nxt;
    logic [FL_W-1:0]    bf_cnt, bf_nxt;

    logic [NREQ-1:0]    pend_mask;
    logic [NREQ-1:0]    eligible;
    logic               win_vld;
    logic [PTR_W-1:0]   win_idx;

    function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] hp,
                                                 input logic [SAT_W-1:0] dmg);
        return (hp > dmg) ? hp - dmg : '0;
    endfunction

    assign char_invul = (inv_cnt != '0);
    assign hit_flash  = {bf_cnt != '0, cf_cnt != '0};

    // A requester whose grant is in flight or being acked must not win again.
    always_comb begin
        int j;
        j         = 0;
        pend_mask = '0;
        if (pend_vld)
            pend_mask[pend_idx] = 1'b1;
        eligible = req & ~ack & ~pend_mask;
        win_vld  = 1'b0;
        win_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (eligible[j]) begin
                win_vld = 1'b1;
                win_idx = PTR_W'(j);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        pend_vld_nxt = 1'b0;
        pend_idx_nxt = pend_idx;
        pend_tgt_nxt = pend_tgt;
        pend_dmg_nxt = pend_dmg;
        ack_nxt      = '0;
        applied_nxt  = 1'b0;
        hp_nxt       = current_health;
        boss_nxt     = boss_hp;
        inv_nxt      = (frame_tick && inv_cnt != '0) ? inv_cnt - INV_W'(1) : inv_cnt;
        cf_nxt       = (frame_tick && cf_cnt != '0) ? cf_cnt - FL_W'(1) : cf_cnt;
        bf_nxt       = (frame_tick && bf_cnt != '0) ? bf_cnt - FL_W'(1) : bf_cnt;

        if (state == RUN && pend_vld) begin
            ack_nxt[pend_idx] = 1'b1;
            if (pend_dmg == '0) begin
                applied_nxt = 1'b1;
            end else if (!pend_tgt) begin
                if (!char_invul) begin
                    applied_nxt = 1'b1;
                    hp_nxt      = 4'(sat_sub(SAT_W'(current_health), SAT_W'(pend_dmg)));
                    inv_nxt     = INV_LOAD;
                    cf_nxt      = FL_LOAD;
                end
            end else begin
                applied_nxt = 1'b1;
                boss_nxt    = 7'(sat_sub(SAT_W'(boss_hp), SAT_W'(pend_dmg)));
                bf_nxt      = FL_LOAD;
            end
            if (applied_nxt && (hp_nxt == '0 || boss_nxt == '0))
                state_nxt = OVER;
        end

        if (state_nxt == RUN && win_vld) begin
            pend_vld_nxt = 1'b1;
            pend_idx_nxt = win_idx;
            pend_tgt_nxt = req_target[win_idx];
            pend_dmg_nxt = req_dmg[int'(win_idx)*DMG_W +: DMG_W];
            ptr_nxt      = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);
        end

        // Reload wins over any grant landing on the same edge.
        if (game_start) begin
            state_nxt    = RUN;
            hp_nxt       = char_hp_max;
            boss_nxt     = BOSS_LOAD;
            ptr_nxt      = '0;
            pend_vld_nxt = 1'b0;
            ack_nxt      = '0;
            applied_nxt  = 1'b0;
            inv_nxt      = '0;
            cf_nxt       = '0;
            bf_nxt       = '0;
        end

        if (back_to_menu) begin
            state_nxt    = IDLE;
            hp_nxt       = current_health;
            boss_nxt     = boss_hp;
            pend_vld_nxt = 1'b0;
            ack_nxt      = '0;
            applied_nxt  = 1'b0;
            inv_nxt      = '0;
            cf_nxt       = '0;
            bf_nxt       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            ptr            <= '0;
            pend_vld       <= 1'b0;
            pend_idx       <= '0;
            pend_tgt       <= 1'b0;
            pend_dmg       <= '0;
            ack            <= '0;
            applied        <= 1'b0;
            current_health <= '0;
            boss_hp        <= '0;
            inv_cnt        <= '0;
            cf_cnt         <= '0;
            bf_cnt         <= '0;
        end else begin
            state          <= state_nxt;
            ptr            <= ptr_nxt;
            pend_vld       <= pend_vld_nxt;
            pend_idx       <= pend_idx_nxt;
            pend_tgt       <= pend_tgt_nxt;
            pend_dmg       <= pend_dmg_nxt;
            ack            <= ack_nxt;
            applied        <= applied_nxt;
            current_health <= hp_nxt;
            boss_hp        <= boss_nxt;
            inv_cnt        <= inv_nxt;
            cf_cnt         <= cf_nxt;
            bf_cnt         <= bf_nxt;
        end
    end
endmodule

// File: tb/tb_damage_arbiter.sv
// Bench for damage_arbiter: an event-level health/arbitration model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_damage_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        game_start = 1'b0;
    logic        back_to_menu = 1'b0;
    logic [3:0]  char_hp_max = '0;
    logic [3:0]  req = '0;
    logic [3:0]  req_target = '0;
    logic [15:0] req_dmg = '0;
    logic [3:0]  ack;
    logic        applied;
    logic [3:0]  current_health;
    logic [6:0]  boss_hp;
    logic        char_invul;
    logic [1:0]  hit_flash;

    int n_cmp = 0;
    int n_bad = 0;

    damage_arbiter dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_start(game_start),
        .back_to_menu(back_to_menu), .char_hp_max(char_hp_max), .req(req),
        .req_target(req_target), .req_dmg(req_dmg), .ack(ack), .applied(applied),
        .current_health(current_health), .boss_hp(boss_hp), .char_invul(char_invul),
        .hit_flash(hit_flash)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: game state 0=menu 1=fight 2=over; pending grant and acked index as ints.
    int m_state = 0, m_ptr = 0, m_pend = -1, m_ptgt = 0, m_pdmg = 0;
    int m_hp = 0, m_boss = 0, m_inv = 0, m_cf = 0, m_bf = 0, m_app = 0, m_ack = -1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state <= 0; m_ptr <= 0; m_pend <= -1; m_ptgt <= 0; m_pdmg <= 0;
            m_hp <= 0; m_boss <= 0; m_inv <= 0; m_cf <= 0; m_bf <= 0;
            m_app <= 0; m_ack <= -1;
        end else begin : step
            int st, hp, boss, inv, cf, bf, app, ackw, pend, ptgt, pdmg, ptr, j;
            st = m_state; hp = m_hp; boss = m_boss; ptr = m_ptr;
            inv = m_inv; cf = m_cf; bf = m_bf;
            ptgt = m_ptgt; pdmg = m_pdmg;
            if (frame_tick) begin
                if (inv > 0) inv--;
                if (cf > 0) cf--;
                if (bf > 0) bf--;
            end
            ackw = -1; app = 0;
            if (m_state == 1 && m_pend >= 0) begin
                ackw = m_pend;
                app = 1;
                if (m_pdmg > 0) begin
                    if (m_ptgt == 0) begin
                        if (m_inv > 0) app = 0;
                        else begin
                            hp = (hp > m_pdmg) ? hp - m_pdmg : 0;
                            inv = 30; cf = 8;
                        end
                    end else begin
                        boss = (boss > m_pdmg) ? boss - m_pdmg : 0;
                        bf = 8;
                    end
                end
                if (app == 1 && (hp == 0 || boss == 0)) st = 2;
            end
            pend = -1;
            if (st == 1) begin
                for (int k = 0; k < 4; k++) begin
                    j = (m_ptr + k) % 4;
                    if (pend < 0 && req[j] && j != m_ack && j != m_pend) begin
                        pend = j;
                        ptgt = int'(req_target[j]);
                        pdmg = int'(req_dmg[j*4 +: 4]);
                        ptr = (j + 1) % 4;
                    end
                end
            end
            if (game_start) begin
                st = 1; hp = int'(char_hp_max); boss = 100; ptr = 0; pend = -1;
                ackw = -1; app = 0; inv = 0; cf = 0; bf = 0;
            end
            if (back_to_menu) begin
                st = 0; hp = m_hp; boss = m_boss; pend = -1;
                ackw = -1; app = 0; inv = 0; cf = 0; bf = 0;
            end
            m_state <= st; m_hp <= hp; m_boss <= boss; m_ptr <= ptr;
            m_inv <= inv; m_cf <= cf; m_bf <= bf; m_app <= app; m_ack <= ackw;
            m_pend <= pend; m_ptgt <= ptgt; m_pdmg <= pdmg;
        end
    end

    always @(negedge clk) begin
        check("cyc_ack", int'(ack), (m_ack >= 0) ? (1 << m_ack) : 0);
        check("cyc_applied", int'(applied), m_app);
        check("cyc_current_health", int'(current_health), m_hp);
        check("cyc_boss_hp", int'(boss_hp), m_boss);
        check("cyc_char_invul", int'(char_invul), int'(m_inv != 0));
        check("cyc_hit_flash", int'(hit_flash), 2 * int'(m_bf != 0) + int'(m_cf != 0));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start_game(input logic [3:0] hp_max);
        char_hp_max = hp_max;
        game_start = 1'b1;
        cyc(1);
        game_start = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(1);
        end
    endtask

    // Requester i raises req, waits (bounded) for its ack, then drops req.
    task automatic fire(input int i, input logic tgt, input logic [3:0] dmg,
                        output int app, output int lat);
        bit got;
        got = 1'b0;
        app = -1;
        lat = -1;
        req_target[i] = tgt;
        req_dmg[i*4 +: 4] = dmg;
        req[i] = 1'b1;
        for (int c = 1; c <= 10 && !got; c++) begin
            cyc(1);
            if (ack[i]) begin
                got = 1'b1;
                app = int'(applied);
                lat = c;
            end
        end
        req[i] = 1'b0;
        check("fire_ack_seen", int'(got), 1);
    endtask

    task automatic count_acks(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            cyc(1);
            if (ack != '0) cnt++;
        end
    endtask

    logic [3:0] seen[$];
    logic [3:0] exp_seq[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int app, lat, cnt, first_c, last_c;

    initial begin
        cyc(3);
        rst = 1'b1;
        cyc(1);
        check("idle_health", int'(current_health), 0);
        check("idle_boss", int'(boss_hp), 0);

        // Load and single player hit
        start_game(4'd5);
        check("load_health", int'(current_health), 5);
        check("load_boss", int'(boss_hp), 100);
        fire(0, 1'b0, 4'd2, app, lat);
        check("hit_applied", app, 1);
        check("hit_latency", lat, 2);
        check("hit_health", int'(current_health), 3);
        check("hit_invul", int'(char_invul), 1);
        check("hit_flash_char", int'(hit_flash), 1);

        // Zero damage is acked and applied but changes nothing
        fire(2, 1'b0, 4'd0, app, lat);
        check("zero_applied", app, 1);
        check("zero_health", int'(current_health), 3);

        // Invulnerable absorbs, then expires after 30 ticks
        fire(1, 1'b0, 4'd3, app, lat);
        check("invul_absorbed", app, 0);
        check("invul_health", int'(current_health), 3);
        ticks(29);
        check("invul_still_on", int'(char_invul), 1);
        check("flash_expired", int'(hit_flash), 0);
        ticks(1);
        check("invul_off", int'(char_invul), 0);
        fire(1, 1'b0, 4'd3, app, lat);
        check("post_invul_applied", app, 1);
        check("player_dead_health", int'(current_health), 0);
        req_target[0] = 1'b1;
        req_dmg[3:0] = 4'd1;
        req[0] = 1'b1;
        count_acks(6, cnt);
        req[0] = 1'b0;
        check("over_no_ack", cnt, 0);

        // Round robin with all four held
        start_game(4'd15);
        req_target = 4'hF;
        req_dmg = 16'h1111;
        req = 4'hF;
        seen.delete();
        first_c = -1;
        last_c = -1;
        for (int c = 0; c < 16 && seen.size() < 5; c++) begin
            cyc(1);
            if (ack != '0) begin
                seen.push_back(ack);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        req = '0;
        check("rr_grant_count", seen.size(), 5);
        for (int k = 0; k < seen.size() && k < 5; k++)
            check("rr_order", int'(seen[k]), int'(exp_seq[k]));
        check("rr_back_to_back", last_c - first_c, 4);
        check("rr_boss_after5", int'(boss_hp), 95);
        cyc(3);
        check("rr_boss_inflight", int'(boss_hp), 94);

        // Boss to 4, then overkill to 0
        repeat (6) fire(2, 1'b1, 4'd15, app, lat);
        check("boss_at_4", int'(boss_hp), 4);
        fire(3, 1'b1, 4'd9, app, lat);
        check("boss_kill_applied", app, 1);
        check("boss_kill_hp", int'(boss_hp), 0);
        check("boss_flash", int'(hit_flash), 2);
        req[0] = 1'b1;
        count_acks(6, cnt);
        req[0] = 1'b0;
        check("boss_over_no_ack", cnt, 0);
        back_to_menu = 1'b1;
        cyc(1);
        back_to_menu = 1'b0;
        check("menu_boss_hold", int'(boss_hp), 0);
        check("menu_health_hold", int'(current_health), 15);
        start_game(4'd7);
        check("restart_boss", int'(boss_hp), 100);
        check("restart_health", int'(current_health), 7);

        // game_start lands on the edge that would produce an ack
        req_target[3] = 1'b0;
        req_dmg[15:12] = 4'd2;
        req[3] = 1'b1;
        cyc(1);
        char_hp_max = 4'd9;
        game_start = 1'b1;
        cyc(1);
        game_start = 1'b0;
        req[3] = 1'b0;
        check("gs_discard_ack", int'(ack), 0);
        check("gs_discard_health", int'(current_health), 9);
        check("gs_discard_boss", int'(boss_hp), 100);
        cyc(2);
        check("gs_discard_later", int'(current_health), 9);

        // Reset mid-RUN
        fire(0, 1'b0, 4'd1, app, lat);
        check("prereset_health", int'(current_health), 8);
        rst = 1'b0;
        #1;
        check("rst_health", int'(current_health), 0);
        check("rst_boss", int'(boss_hp), 0);
        check("rst_invul", int'(char_invul), 0);
        check("rst_flash", int'(hit_flash), 0);
        cyc(3);
        rst = 1'b1;
        req = 4'hF;
        count_acks(5, cnt);
        req = '0;
        check("rst_idle_no_ack", cnt, 0);
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
